uart_pass_lock: RTL and testbench

- Parametrised password checker between the UART receiver (byte/valid) and the UART transmitter (byte/valid/ready) in top-level designs.
- Collects fixed-length password attempts from the RX byte stream and compares them on the fly.
- Answers each attempt with a 3-byte response string over TX and drives lock/unlock status to LEDs.
- Adds over the current fixed-password design: configurable length and password, consecutive-failure lockout with timer, abort and relock characters.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_resp_sender.sv | 44 ++++
 rtl/uart_pass_lock.sv | 142 ++++++++++++++
 tb/tb_uart_pass_lock.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART command-block definitions: response strings, FSM state encoding
// and the control characters used by the UART command blocks.
package uart_pkg;

   localparam logic [23:0] RESP_OK = "OK\n";
   localparam logic [23:0] RESP_NO = "NO\n";
   localparam logic [23:0] RESP_LK = "LK\n";

   localparam logic [7:0] ESC  = 8'h1B;
   localparam logic [7:0] HASH = 8'h23;

   typedef enum logic [1:0] {
      ST_COLLECT,
      ST_RESP,
      ST_UNLOCKED,
      ST_LOCKOUT
   } state_t;

endpackage

// File: rtl/uart_resp_sender.sv
// Serialises one 3-byte string onto a valid/ready byte interface, MSB byte first.
// done is combinational on the last handshake so callers can change state on that edge.
module uart_resp_sender (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [23:0] str,
   input  logic        tx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   output logic        busy,
   output logic        done
);

   logic [23:0] str_q;
   logic [1:0]  idx;

   assign busy = tx_valid;
   assign done = tx_valid && tx_ready && (idx == 2'd2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_valid <= 1'b0;
         tx_data  <= '0;
         str_q    <= '0;
         idx      <= '0;
      end else if (!tx_valid) begin
         if (start) begin
            tx_valid <= 1'b1;
            tx_data  <= str[23:16];
            str_q    <= str;
            idx      <= '0;
         end
      end else if (tx_ready) begin
         if (idx == 2'd2) begin
            tx_valid <= 1'b0;
         end else begin
            idx     <= idx + 1'b1;
            tx_data <= (idx == 2'd0) ? str_q[15:8] : str_q[7:0];
         end
      end
   end

endmodule

// File: rtl/uart_pass_lock.sv
// Password checker between UART RX and TX: collects fixed-length attempts,
// answers OK/NO/LK, and locks out after repeated consecutive failures.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_COLLECT  | gathering attempt bytes, comparing against PASSWORD on the fly
// ST_RESP     | response string in flight; exits to post_state on last handshake
// ST_UNLOCKED | access granted; only RELOCK_CHAR is acted upon
// ST_LOCKOUT  | too many failures; down-counter runs, RX bytes are dropped
module uart_pass_lock
   import uart_pkg::*;
#(
   parameter int                    PASS_LEN       = 4,
   parameter logic [8*PASS_LEN-1:0] PASSWORD       = "1a2B",
   parameter int                    MAX_FAILS      = 3,
   parameter int                    LOCKOUT_CYCLES = 1024,
   parameter logic [7:0]            ABORT_CHAR     = ESC,
   parameter logic [7:0]            RELOCK_CHAR    = HASH
) (
   input  logic                             clk,
   input  logic                             btn,
   input  logic [7:0]                       rx_data,
   input  logic                             rx_valid,
   output logic [7:0]                       tx_data,
   output logic                             tx_valid,
   input  logic                             tx_ready,
   output logic                             unlocked,
   output logic                             locked_out,
   output logic [$clog2(MAX_FAILS+1)-1:0]   fail_cnt,
   output logic [$clog2(PASS_LEN+1)-1:0]    char_idx
);

   localparam int CW = $clog2(PASS_LEN+1);
   localparam int FW = $clog2(MAX_FAILS+1);
   localparam int TW = $clog2(LOCKOUT_CYCLES);

   state_t          state;
   state_t          post_state;
   logic            mismatch;
   logic [TW-1:0]   timer;

   // Padded to a power of two so char_idx indexes it at its natural width.
   logic [7:0] pw_arr [2**CW];
   for (genvar i = 0; i < 2**CW; i++) begin : g_pw
      if (i < PASS_LEN) begin : g_byte
         assign pw_arr[i] = PASSWORD[8*(PASS_LEN-1-i) +: 8];
      end else begin : g_pad
         assign pw_arr[i] = '0;
      end
   end

   logic        is_abort, last_byte, miss_now;
   logic        snd_start, snd_busy, snd_done;
   logic [23:0] snd_str;

   assign is_abort  = (rx_data == ABORT_CHAR);
   assign last_byte = (char_idx == CW'(PASS_LEN-1));
   assign miss_now  = mismatch | (rx_data != pw_arr[char_idx]);

   assign snd_start = rx_valid && !snd_busy &&
                      (((state == ST_COLLECT) && !is_abort && last_byte) ||
                       ((state == ST_UNLOCKED) && (rx_data == RELOCK_CHAR)));
   assign snd_str   = (state == ST_UNLOCKED) ? RESP_LK : (miss_now ? RESP_NO : RESP_OK);

   uart_resp_sender u_sender (
      .clk      (clk),
      .rst_n    (btn),
      .start    (snd_start),
      .str      (snd_str),
      .tx_ready (tx_ready),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .busy     (snd_busy),
      .done     (snd_done)
   );

   always_ff @(posedge clk or negedge btn) begin
      if (!btn) begin
         state      <= ST_COLLECT;
         post_state <= ST_COLLECT;
         unlocked   <= 1'b0;
         locked_out <= 1'b0;
         fail_cnt   <= '0;
         char_idx   <= '0;
         mismatch   <= 1'b0;
         timer      <= '0;
      end else begin
         case (state)
            ST_COLLECT: begin
               if (rx_valid) begin
                  if (is_abort) begin
                     char_idx <= '0;
                     mismatch <= 1'b0;
                  end else if (last_byte) begin
                     state    <= ST_RESP;
                     char_idx <= '0;
                     mismatch <= 1'b0;
                     if (!miss_now) begin
                        fail_cnt   <= '0;
                        post_state <= ST_UNLOCKED;
                     end else begin
                        if (fail_cnt != FW'(MAX_FAILS))
                           fail_cnt <= fail_cnt + 1'b1;
                        post_state <= (fail_cnt >= FW'(MAX_FAILS-1)) ? ST_LOCKOUT : ST_COLLECT;
                     end
                  end else begin
                     char_idx <= char_idx + 1'b1;
                     mismatch <= miss_now;
                  end
               end
            end
            ST_RESP: begin
               if (snd_done) begin
                  state    <= post_state;
                  unlocked <= (post_state == ST_UNLOCKED);
                  if (post_state == ST_LOCKOUT) begin
                     locked_out <= 1'b1;
                     timer      <= TW'(LOCKOUT_CYCLES-1);
                  end
               end
            end
            ST_UNLOCKED: begin
               if (rx_valid && (rx_data == RELOCK_CHAR)) begin
                  state      <= ST_RESP;
                  post_state <= ST_COLLECT;
               end
            end
            ST_LOCKOUT: begin
               if (timer == '0) begin
                  locked_out <= 1'b0;
                  fail_cnt   <= '0;
                  state      <= ST_COLLECT;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            default: state <= ST_COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_pass_lock.sv
// Directed bench for uart_pass_lock: a table of attempts with expected responses
// and status, followed by lockout, backpressure and mid-response reset sequences.
module tb_uart_pass_lock;

   logic       clk = 1'b0;
   logic       btn;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       unlocked;
   logic       locked_out;
   logic [1:0] fail_cnt;
   logic [2:0] char_idx;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   uart_pass_lock dut (
      .clk        (clk),
      .btn        (btn),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .unlocked   (unlocked),
      .locked_out (locked_out),
      .fail_cnt   (fail_cnt),
      .char_idx   (char_idx)
   );

   typedef struct {
      string       name;
      logic [63:0] bytes;
      int          len;
      bit          has_resp;
      logic [23:0] resp;
      logic        exp_unl;
      logic [1:0]  exp_fail;
      logic [2:0]  exp_idx;
      logic        exp_lock;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   task automatic expect_resp(input string name, input logic [23:0] exp,
                              input bit wait_first, input bit chk_lat);
      logic [23:0] got;
      int w;
      got = '0;
      if (wait_first) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         w = 0;
         while (!tx_valid && w < 50) begin
            @(negedge clk);
            w++;
         end
         if (k == 0 && chk_lat) chk({name, "_latency"}, w, 0);
         got[8*(2-k) +: 8] = tx_valid ? tx_data : 8'h00;
         @(negedge clk);
      end
      chk(name, {8'h0, got}, {8'h0, exp});
      chk({name, "_valid_drop"}, {31'h0, tx_valid}, 0);
   endtask

   task automatic expect_silence(input string name, input int cycles);
      bit seen;
      seen = 1'b0;
      repeat (cycles) begin
         @(negedge clk);
         if (tx_valid) seen = 1'b1;
      end
      chk(name, {31'h0, seen}, 0);
   endtask

   initial begin
      logic [31:0] pw;
      int   cnt;
      bit   tx_seen;
      bit   hold_ok;

      pw       = "1a2B";
      btn      = 1'b0;
      rx_data  = '0;
      rx_valid = 1'b0;
      tx_ready = 1'b1;

      vecs[0]  = '{"ok_first",    64'("1a2B"), 4, 1'b1, "OK\n", 1'b1, 2'd0, 3'd0, 1'b0};
      vecs[1]  = '{"ignore_unl",  64'("Z"),    1, 1'b0, 24'h0,  1'b1, 2'd0, 3'd0, 1'b0};
      vecs[2]  = '{"relock",      64'("#"),    1, 1'b1, "LK\n", 1'b0, 2'd0, 3'd0, 1'b0};
      vecs[3]  = '{"bad_last",    64'("1a22"), 4, 1'b1, "NO\n", 1'b0, 2'd1, 3'd0, 1'b0};
      vecs[4]  = '{"partial",     64'("9a"),   2, 1'b0, 24'h0,  1'b0, 2'd1, 3'd2, 1'b0};
      vecs[5]  = '{"abort",       64'h1B,      1, 1'b0, 24'h0,  1'b0, 2'd1, 3'd0, 1'b0};
      vecs[6]  = '{"ok_after_esc",64'("1a2B"), 4, 1'b1, "OK\n", 1'b1, 2'd0, 3'd0, 1'b0};
      vecs[7]  = '{"relock2",     64'("#"),    1, 1'b1, "LK\n", 1'b0, 2'd0, 3'd0, 1'b0};
      vecs[8]  = '{"fail1",       64'("xxxx"), 4, 1'b1, "NO\n", 1'b0, 2'd1, 3'd0, 1'b0};
      vecs[9]  = '{"fail2",       64'("xxxx"), 4, 1'b1, "NO\n", 1'b0, 2'd2, 3'd0, 1'b0};
      vecs[10] = '{"fail3_lock",  64'("xxxx"), 4, 1'b1, "NO\n", 1'b0, 2'd3, 3'd0, 1'b1};

      #1;
      chk("rst_outputs", {tx_data, tx_valid, unlocked, locked_out, fail_cnt, char_idx},
          {8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0});
      repeat (3) @(negedge clk);
      btn = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 11; i++) begin
         for (int j = 0; j < vecs[i].len; j++)
            send_byte(vecs[i].bytes[8*(vecs[i].len-1-j) +: 8]);
         if (vecs[i].has_resp) expect_resp(vecs[i].name, vecs[i].resp, 1'b1, 1'b1);
         else                  expect_silence(vecs[i].name, 5);
         chk({vecs[i].name, "_unlocked"},   {31'h0, unlocked},   {31'h0, vecs[i].exp_unl});
         chk({vecs[i].name, "_fail_cnt"},   {30'h0, fail_cnt},   {30'h0, vecs[i].exp_fail});
         chk({vecs[i].name, "_char_idx"},   {29'h0, char_idx},   {29'h0, vecs[i].exp_idx});
         chk({vecs[i].name, "_locked_out"}, {31'h0, locked_out}, {31'h0, vecs[i].exp_lock});
      end

      // Lockout: count its length while feeding the correct password, which must be dropped.
      cnt     = 1;
      tx_seen = 1'b0;
      while (locked_out && cnt < 2000) begin
         if (cnt >= 10 && cnt < 18 && cnt[0] == 1'b0) begin
            rx_data  = pw[8*(3-(cnt-10)/2) +: 8];
            rx_valid = 1'b1;
         end else begin
            rx_valid = 1'b0;
         end
         @(negedge clk);
         if (tx_valid) tx_seen = 1'b1;
         if (locked_out) cnt++;
      end
      rx_valid = 1'b0;
      chk("lockout_len", cnt, 1024);
      chk("lockout_no_tx", {31'h0, tx_seen}, 0);
      chk("lockout_fail_clr", {30'h0, fail_cnt}, 0);
      chk("lockout_idx", {29'h0, char_idx}, 0);
      for (int j = 0; j < 4; j++) send_byte(pw[8*(3-j) +: 8]);
      expect_resp("ok_after_lockout", "OK\n", 1'b1, 1'b1);
      chk("ok_after_lockout_unl", {31'h0, unlocked}, 1);

      send_byte("#");
      expect_resp("relock3", "LK\n", 1'b1, 1'b1);

      // Backpressure: first byte must hold for 20 cycles, then the full string follows.
      tx_ready = 1'b0;
      for (int j = 0; j < 4; j++) send_byte(pw[8*(3-j) +: 8]);
      hold_ok = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (!(tx_valid && tx_data == 8'h4F)) hold_ok = 1'b0;
      end
      chk("bp_hold", {31'h0, hold_ok}, 1);
      tx_ready = 1'b1;
      expect_resp("bp_resp", "OK\n", 1'b0, 1'b0);
      chk("bp_unlocked", {31'h0, unlocked}, 1);

      // Reset in the middle of the LK response.
      tx_ready = 1'b0;
      send_byte("#");
      @(negedge clk);
      chk("mid_resp_valid", {tx_valid, tx_data}, {1'b1, 8'h4C});
      #2 btn = 1'b0;
      #1;
      chk("async_rst_outputs", {tx_data, tx_valid, unlocked, locked_out, fail_cnt, char_idx},
          {8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0});
      @(negedge clk);
      btn      = 1'b1;
      tx_ready = 1'b1;
      expect_silence("post_rst_idle", 5);
      for (int j = 0; j < 4; j++) send_byte(pw[8*(3-j) +: 8]);
      expect_resp("ok_after_rst", "OK\n", 1'b1, 1'b1);
      chk("ok_after_rst_unl", {31'h0, unlocked}, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
